dmem_arbiter: RTL and testbench

Two-port arbiter and sequencer in front of the single-port data memory. It shares that memory between the core's load/store port (C) and a DMA/debug loader port (D). Each cycle it grants at most one access, drives the memory's read/write strobes, address and write data, and returns registered read data to the winning requester one cycle later. It sits between the core datapath, the loader, and the data memory.

---
 rtl/dmem_pkg.sv | 14 +
 rtl/dmem_arb_pick.sv | 36 +++
 rtl/dmem_arbiter.sv | 136 +++++++++++++
 tb/tb_dmem_arbiter.sv | 254 +++++++++++++++++++++++++
 4 files changed

// File: rtl/dmem_pkg.sv
// Shared definitions for the data-memory arbiter and the data memory itself.
package dmem_pkg;

  localparam int unsigned DMEM_ADDR_WIDTH = 32;
  localparam int unsigned DMEM_DATA_WIDTH = 32;
  localparam int unsigned DMEM_RAM_HEIGHT = 2048;

  typedef enum logic [1:0] {
    SEL_NONE,
    SEL_C,
    SEL_D
  } port_sel_t;

endpackage

// File: rtl/dmem_arb_pick.sv
// Pure pick logic for the dmem arbiter.
// DMEM_ARBITER_RR_EN selects round-robin on conflict; otherwise fixed C priority with starve override.
module dmem_arb_pick
  import dmem_pkg::*;
(
  input  logic      c_req,
  input  logic      d_req,
  input  logic      last_d,
  input  logic      starve,
  output port_sel_t sel
);

  always_comb begin
    sel = SEL_NONE;
    if (c_req && d_req) begin
`ifdef DMEM_ARBITER_RR_EN
      sel = last_d ? SEL_C : SEL_D;
`else
      sel = starve ? SEL_D : SEL_C;
`endif
    end else if (c_req) begin
      sel = SEL_C;
    end else if (d_req) begin
      sel = SEL_D;
    end
  end

`ifdef DMEM_ARBITER_RR_EN
  logic unused_starve;
  assign unused_starve = starve;
`else
  logic unused_last_d;
  assign unused_last_d = last_d;
`endif

endmodule

// File: rtl/dmem_arbiter.sv
// Two-port (core C / loader D) arbiter in front of the single-port data memory.
// Define DMEM_ARBITER_RR_EN for round-robin conflicts instead of fixed priority with starve override.
module dmem_arbiter
  import dmem_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH   = DMEM_ADDR_WIDTH,
  parameter int unsigned DATA_WIDTH   = DMEM_DATA_WIDTH,
  parameter int unsigned RAM_HEIGHT   = DMEM_RAM_HEIGHT,
  parameter int unsigned STARVE_LIMIT = 4
) (
  input  logic                  clk,
  input  logic                  rst_,
  input  logic                  c_req,
  input  logic                  c_we,
  input  logic [ADDR_WIDTH-1:0] c_addr,
  input  logic [DATA_WIDTH-1:0] c_wdata,
  output logic                  c_gnt,
  output logic                  c_rvalid,
  output logic [DATA_WIDTH-1:0] c_rdata,
  output logic                  c_err,
  input  logic                  d_req,
  input  logic                  d_we,
  input  logic [ADDR_WIDTH-1:0] d_addr,
  input  logic [DATA_WIDTH-1:0] d_wdata,
  output logic                  d_gnt,
  output logic                  d_rvalid,
  output logic [DATA_WIDTH-1:0] d_rdata,
  output logic                  d_err,
  output logic                  mem_rd,
  output logic                  mem_wrt,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  input  logic [DATA_WIDTH-1:0] mem_rdata
);

  port_sel_t             sel;
  logic                  last_d_q;
  logic                  starve;
  logic                  win_c, win_d;
  logic                  win_we;
  logic [ADDR_WIDTH-1:0] win_addr;
  logic [DATA_WIDTH-1:0] win_wdata;
  logic                  in_range;
  logic                  c_rd_ok, d_rd_ok;
  logic                  c_rvalid_q, d_rvalid_q, c_err_q, d_err_q;
  logic [DATA_WIDTH-1:0] c_rdata_q, d_rdata_q;

  dmem_arb_pick u_pick (
    .c_req  (c_req),
    .d_req  (d_req),
    .last_d (last_d_q),
    .starve (starve),
    .sel    (sel)
  );

  // Address/data follow the pick even in reset; only grants and strobes are gated.
  always_comb begin
    win_we    = 1'b0;
    win_addr  = '0;
    win_wdata = '0;
    unique case (sel)
      SEL_C: begin
        win_we    = c_we;
        win_addr  = c_addr;
        win_wdata = c_wdata;
      end
      SEL_D: begin
        win_we    = d_we;
        win_addr  = d_addr;
        win_wdata = d_wdata;
      end
      default: ;
    endcase
  end

  assign win_c    = rst_ && (sel == SEL_C);
  assign win_d    = rst_ && (sel == SEL_D);
  assign in_range = 64'(win_addr) < 64'(RAM_HEIGHT);

  assign c_gnt     = win_c;
  assign d_gnt     = win_d;
  assign mem_rd    = (win_c || win_d) && in_range && !win_we;
  assign mem_wrt   = (win_c || win_d) && in_range && win_we;
  assign mem_addr  = win_addr;
  assign mem_wdata = win_wdata;

  assign c_rd_ok = win_c && in_range && !win_we;
  assign d_rd_ok = win_d && in_range && !win_we;

  always_ff @(posedge clk or negedge rst_) begin
    if (!rst_) begin
      c_rvalid_q <= 1'b0;
      d_rvalid_q <= 1'b0;
      c_err_q    <= 1'b0;
      d_err_q    <= 1'b0;
      c_rdata_q  <= '0;
      d_rdata_q  <= '0;
      last_d_q   <= 1'b1;
    end else begin
      c_rvalid_q <= c_rd_ok;
      d_rvalid_q <= d_rd_ok;
      c_err_q    <= win_c && !in_range;
      d_err_q    <= win_d && !in_range;
      if (c_rd_ok) c_rdata_q <= mem_rdata;
      if (d_rd_ok) d_rdata_q <= mem_rdata;
      if (c_req && d_req) last_d_q <= win_d;
    end
  end

`ifndef DMEM_ARBITER_RR_EN
  localparam int unsigned CntW = (STARVE_LIMIT > 0) ? $clog2(STARVE_LIMIT + 1) : 1;
  logic [CntW-1:0] starve_cnt_q;

  always_ff @(posedge clk or negedge rst_) begin
    if (!rst_) begin
      starve_cnt_q <= '0;
    end else if (!d_req || win_d) begin
      starve_cnt_q <= '0;
    end else if (starve_cnt_q != CntW'(STARVE_LIMIT)) begin
      starve_cnt_q <= starve_cnt_q + 1'b1;
    end
  end

  assign starve = (starve_cnt_q == CntW'(STARVE_LIMIT));
`else
  assign starve = 1'b0;
`endif

  assign c_rvalid = c_rvalid_q;
  assign d_rvalid = d_rvalid_q;
  assign c_err    = c_err_q;
  assign d_err    = d_err_q;
  assign c_rdata  = c_rdata_q;
  assign d_rdata  = d_rdata_q;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Self-checking bench for dmem_arbiter: per-cycle reference model plus directed literal checks.
module tb_dmem_arbiter;

  localparam int H     = 2048;
  localparam int LIMIT = 4;

  logic        clk, rst_;
  logic        c_req, c_we, d_req, d_we;
  logic [31:0] c_addr, c_wdata, d_addr, d_wdata;
  logic        c_gnt, c_rvalid, c_err, d_gnt, d_rvalid, d_err;
  logic [31:0] c_rdata, d_rdata;
  logic        mem_rd, mem_wrt;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;

  int n_checks = 0;
  int n_fail   = 0;

  dmem_arbiter #(
    .ADDR_WIDTH   (32),
    .DATA_WIDTH   (32),
    .RAM_HEIGHT   (H),
    .STARVE_LIMIT (LIMIT)
  ) dut (
    .clk       (clk),
    .rst_      (rst_),
    .c_req     (c_req),
    .c_we      (c_we),
    .c_addr    (c_addr),
    .c_wdata   (c_wdata),
    .c_gnt     (c_gnt),
    .c_rvalid  (c_rvalid),
    .c_rdata   (c_rdata),
    .c_err     (c_err),
    .d_req     (d_req),
    .d_we      (d_we),
    .d_addr    (d_addr),
    .d_wdata   (d_wdata),
    .d_gnt     (d_gnt),
    .d_rvalid  (d_rvalid),
    .d_rdata   (d_rdata),
    .d_err     (d_err),
    .mem_rd    (mem_rd),
    .mem_wrt   (mem_wrt),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Data memory seen by the DUT: combinational read, write at the edge.
  logic [31:0] ram [0:H-1];
  assign mem_rdata = (mem_addr < H) ? ram[mem_addr[10:0]] : 32'h0;
  always @(posedge clk) begin
    if (mem_wrt && mem_addr < H) ram[mem_addr[10:0]] <= mem_wdata;
  end

  // Reference model state.
  logic [31:0] ref_mem [0:H-1];
  int          m_denied;
  bit          m_last_d;
  bit          e_crv, e_cerr, e_drv, e_derr;
  bit   [31:0] e_crd, e_drd;

  // 0 = none, 1 = C, 2 = D; ignores reset gating.
  function automatic int model_winner();
    if (c_req && d_req) begin
`ifdef DMEM_ARBITER_RR_EN
      return m_last_d ? 1 : 2;
`else
      return (m_denied >= LIMIT) ? 2 : 1;
`endif
    end
    if (c_req) return 1;
    if (d_req) return 2;
    return 0;
  endfunction

  always @(posedge clk or negedge rst_) begin
    int          w;
    logic [31:0] a, wd;
    bit          we, inr;
    if (!rst_) begin
      m_denied <= 0;
      m_last_d <= 1'b1;
      e_crv <= 1'b0; e_cerr <= 1'b0; e_drv <= 1'b0; e_derr <= 1'b0;
      e_crd <= 32'h0; e_drd <= 32'h0;
    end else begin
      w   = model_winner();
      a   = (w == 1) ? c_addr : d_addr;
      wd  = (w == 1) ? c_wdata : d_wdata;
      we  = (w == 1) ? c_we : d_we;
      inr = a < H;
      e_crv  <= (w == 1) && inr && !we;
      e_drv  <= (w == 2) && inr && !we;
      e_cerr <= (w == 1) && !inr;
      e_derr <= (w == 2) && !inr;
      if (w == 1 && inr && !we) e_crd <= ref_mem[a[10:0]];
      if (w == 2 && inr && !we) e_drd <= ref_mem[a[10:0]];
      if (w != 0 && inr && we) ref_mem[a[10:0]] <= wd;
      if (!d_req || w == 2) m_denied <= 0;
      else if (m_denied < LIMIT) m_denied <= m_denied + 1;
      if (c_req && d_req) m_last_d <= (w == 2);
    end
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic compare();
    int          raw, g;
    logic [31:0] ea, ewd;
    bit          ewe, inr;
    raw = model_winner();
    g   = rst_ ? raw : 0;
    ea  = (raw == 1) ? c_addr : (raw == 2) ? d_addr : 32'h0;
    ewd = (raw == 1) ? c_wdata : (raw == 2) ? d_wdata : 32'h0;
    ewe = (raw == 1) ? c_we : (raw == 2) ? d_we : 1'b0;
    inr = ea < H;
    chk("c_gnt", 64'(c_gnt), 64'(g == 1));
    chk("d_gnt", 64'(d_gnt), 64'(g == 2));
    chk("mem_rd", 64'(mem_rd), 64'(g != 0 && inr && !ewe));
    chk("mem_wrt", 64'(mem_wrt), 64'(g != 0 && inr && ewe));
    chk("mem_addr", 64'(mem_addr), 64'(ea));
    chk("mem_wdata", 64'(mem_wdata), 64'(ewd));
    chk("c_rvalid", 64'(c_rvalid), 64'(e_crv));
    chk("c_rdata", 64'(c_rdata), 64'(e_crd));
    chk("c_err", 64'(c_err), 64'(e_cerr));
    chk("d_rvalid", 64'(d_rvalid), 64'(e_drv));
    chk("d_rdata", 64'(d_rdata), 64'(e_drd));
    chk("d_err", 64'(d_err), 64'(e_derr));
  endtask

  // Drive one cycle's inputs just after the edge and return before mid-cycle.
  task automatic step(input bit cr, input bit cw, input logic [31:0] ca, input logic [31:0] cd,
                      input bit dr, input bit dw, input logic [31:0] da, input logic [31:0] dd);
    @(posedge clk);
    #1;
    c_req = cr; c_we = cw; c_addr = ca; c_wdata = cd;
    d_req = dr; d_we = dw; d_addr = da; d_wdata = dd;
    #3;
  endtask

  task automatic idle();
    step(0, 0, 32'h0, 32'h0, 0, 0, 32'h0, 32'h0);
  endtask

  initial begin
    bit exp_d;
    rst_ = 1'b0;
    c_req = 0; c_we = 0; c_addr = 0; c_wdata = 0;
    d_req = 0; d_we = 0; d_addr = 0; d_wdata = 0;
    fork
      forever begin
        @(negedge clk);
        compare();
      end
    join_none
    repeat (2) @(posedge clk);
    #2 rst_ = 1'b1;
    @(posedge clk);
    #4;
    chk("reset c_rvalid", 64'(c_rvalid), 64'd0);
    chk("reset c_rdata", 64'(c_rdata), 64'd0);
    chk("reset d_err", 64'(d_err), 64'd0);

    // C write then read of address 5.
    step(1, 1, 32'd5, 32'hDEADBEEF, 0, 0, 0, 0);
    chk("wr5 c_gnt", 64'(c_gnt), 64'd1);
    chk("wr5 mem_wrt", 64'(mem_wrt), 64'd1);
    step(1, 0, 32'd5, 32'h0, 0, 0, 0, 0);
    chk("rd5 c_gnt", 64'(c_gnt), 64'd1);
    chk("rd5 mem_rd", 64'(mem_rd), 64'd1);
    idle();
    chk("rd5 c_rvalid", 64'(c_rvalid), 64'd1);
    chk("rd5 c_rdata", 64'(c_rdata), 64'hDEADBEEF);
    chk("rd5 d_rvalid", 64'(d_rvalid), 64'd0);
    chk("rd5 d_rdata", 64'(d_rdata), 64'd0);

    // Cross-port read after write of address 7.
    step(1, 1, 32'd7, 32'h11, 0, 0, 0, 0);
    step(0, 0, 0, 0, 1, 0, 32'd7, 32'h0);
    chk("raw7 d_gnt", 64'(d_gnt), 64'd1);
    idle();
    chk("raw7 d_rvalid", 64'(d_rvalid), 64'd1);
    chk("raw7 d_rdata", 64'(d_rdata), 64'h11);

    // Ten cycles of conflicting reads.
    for (int i = 1; i <= 10; i++) begin
      step(1, 0, 32'd5, 32'h0, 1, 0, 32'd7, 32'h0);
`ifdef DMEM_ARBITER_RR_EN
      exp_d = (i % 2) == 0;
`else
      exp_d = (i % 5) == 0;
`endif
      chk("conflict d_gnt", 64'(d_gnt), 64'(exp_d));
      chk("conflict c_gnt", 64'(c_gnt), 64'(!exp_d));
    end
    idle();

    // Out-of-range accesses from D.
    step(0, 0, 0, 0, 1, 1, 32'd2048, 32'h55);
    chk("oor wr d_gnt", 64'(d_gnt), 64'd1);
    chk("oor wr mem_wrt", 64'(mem_wrt), 64'd0);
    idle();
    chk("oor wr d_err", 64'(d_err), 64'd1);
    idle();
    chk("oor wr d_err pulse", 64'(d_err), 64'd0);
    step(0, 0, 0, 0, 1, 0, 32'd4000, 32'h0);
    chk("oor rd mem_rd", 64'(mem_rd), 64'd0);
    idle();
    chk("oor rd d_err", 64'(d_err), 64'd1);
    chk("oor rd d_rvalid", 64'(d_rvalid), 64'd0);

    // Back-to-back C reads.
    step(1, 0, 32'd5, 32'h0, 0, 0, 0, 0);
    step(1, 0, 32'd7, 32'h0, 0, 0, 0, 0);
    chk("b2b c_rdata 1", 64'(c_rdata), 64'hDEADBEEF);
    step(1, 0, 32'd5, 32'h0, 0, 0, 0, 0);
    chk("b2b c_rvalid 2", 64'(c_rvalid), 64'd1);
    chk("b2b c_rdata 2", 64'(c_rdata), 64'h11);
    idle();
    chk("b2b c_rvalid 3", 64'(c_rvalid), 64'd1);
    chk("b2b c_rdata 3", 64'(c_rdata), 64'hDEADBEEF);

    // Reset asserted right after a granted read.
    step(1, 0, 32'd7, 32'h0, 0, 0, 0, 0);
    chk("rst rd c_gnt", 64'(c_gnt), 64'd1);
    #2 rst_ = 1'b0;
    @(posedge clk);
    #4;
    chk("rst c_rvalid", 64'(c_rvalid), 64'd0);
    chk("rst c_rdata", 64'(c_rdata), 64'd0);
    chk("rst c_gnt", 64'(c_gnt), 64'd0);
    chk("rst mem_rd", 64'(mem_rd), 64'd0);
    #2 rst_ = 1'b1;
    step(1, 0, 32'd7, 32'h0, 0, 0, 0, 0);
    idle();
    chk("post rst c_rvalid", 64'(c_rvalid), 64'd1);
    chk("post rst c_rdata", 64'(c_rdata), 64'h11);
    idle();
    idle();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
